// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8-channel TDM demultiplexer.
// TDM_PARITY_EN adds a trailing even-parity beat to every frame.
package tdm_pkg;

  localparam int NCH = 8;
  localparam int SLOT_W = $clog2(NCH + 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef TDM_PARITY_EN
  localparam int FRAME_LEN = NCH + 1;
  localparam int NSHADOW = NCH;
`else
  localparam int FRAME_LEN = NCH;
  localparam int NSHADOW = NCH - 1;
`endif

endpackage

// File: rtl/tdm_demux8_if.sv
// Serial TDM input and demultiplexed channel outputs of tdm_demux8.
// Compile with TDM_PARITY_EN to give parity_err a meaning.
interface tdm_demux8_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic [NCH*WIDTH-1:0] data_o;
  logic                 frame_valid;
  logic                 locked;
  logic                 sync_err;
  logic                 parity_err;

  modport master (
    output din, din_valid, frame_sync,
    input  data_o, frame_valid, locked,
    input  sync_err, parity_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output data_o, frame_valid, locked,
    output sync_err, parity_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index within the current frame; wraps after the last slot.
// Frame length grows by one parity beat under TDM_PARITY_EN.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load1,
  input  logic              clear,
  output logic [SLOT_W-1:0] cnt,
  output logic              last
);

  logic [SLOT_W-1:0] r_cnt;

  assign last = (r_cnt == SLOT_W'(FRAME_LEN - 1));
  assign cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (load1) begin
      r_cnt <= SLOT_W'(1);
    end else if (inc) begin
      r_cnt <= last ? '0 : r_cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// 8-channel TDM demultiplexer publishing a full frame atomically.
// TDM_PARITY_EN: 9-beat frames with an even-parity check beat.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst,
  tdm_demux8_if.slave bus
);

  state_t                   r_state;
  logic [NSHADOW*WIDTH-1:0] r_shadow;
  logic [NCH*WIDTH-1:0]     r_data;
  logic                     r_fv;
  logic                     r_serr;
  logic                     r_perr;

  logic [SLOT_W-1:0]    w_cnt;
  logic                 w_last;
  logic                 w_beat;
  logic                 w_sync;
  logic                 w_run;
  logic                 w_c0;
  logic                 w_load1;
  logic                 w_early;
  logic                 w_miss;
  logic                 w_store;
  logic                 w_end;
  logic                 w_commit;
  logic                 w_perr;
  logic [NCH*WIDTH-1:0] w_frame;

  assign w_beat  = bus.din_valid;
  assign w_sync  = bus.frame_sync;
  assign w_run   = (r_state == RUN);
  assign w_c0    = (w_cnt == '0);
  assign w_load1 = w_beat & w_sync;
  assign w_early = w_load1 & w_run & ~w_c0;
  assign w_miss  = w_beat & ~w_sync & w_run & w_c0;
  assign w_store = w_beat & ~w_sync & w_run & ~w_c0;
  assign w_end   = w_store & w_last;

`ifdef TDM_PARITY_EN
  // Even parity: the check bit equals the XOR of all data bits.
  logic w_par_ok;
  assign w_par_ok = (bus.din[0] == ^r_shadow);
  assign w_frame  = r_shadow;
  assign w_commit = w_end & w_par_ok;
  assign w_perr   = w_end & ~w_par_ok;
`else
  assign w_frame  = {bus.din, r_shadow};
  assign w_commit = w_end;
  assign w_perr   = 1'b0;
`endif

  tdm_slot_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_store),
    .load1 (w_load1),
    .clear (w_miss),
    .cnt   (w_cnt),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HUNT;
      r_shadow <= '0;
      r_data   <= '0;
      r_fv     <= 1'b0;
      r_serr   <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_fv   <= w_commit;
      r_serr <= w_early | w_miss;
      r_perr <= w_perr;
      if (w_miss) begin
        r_state <= HUNT;
      end else if (w_load1) begin
        r_state <= RUN;
      end
      if (w_load1) begin
        r_shadow[0 +: WIDTH] <= bus.din;
      end else if (w_store) begin
        for (int k = 1; k < NSHADOW; k++) begin
          if (w_cnt == SLOT_W'(k)) begin
            r_shadow[k*WIDTH +: WIDTH] <= bus.din;
          end
        end
      end
      if (w_commit) begin
        r_data <= w_frame;
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.frame_valid = r_fv;
  assign bus.locked      = w_run;
  assign bus.sync_err    = r_serr;
  assign bus.parity_err  = r_perr;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8.
// Parity scenarios run when TDM_PARITY_EN is defined.
module tb_tdm_demux8;

`ifdef TDM_PARITY_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tdm_demux8_if #(.WIDTH(W)) bus ();

  tdm_demux8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic s);
    bus.din_valid  = v;
    bus.din        = d;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.frame_sync = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_lock", bus.locked, 0);
    chk("rst_serr", bus.sync_err, 0);
    chk("rst_perr", bus.parity_err, 0);
    rst = 1'b0;
    step(0, 0, 0);

`ifdef TDM_PARITY_EN
    // slots 3,0..0 with correct parity 0
    step(1, 3, 1);
    for (int k = 1; k < 8; k++) step(1, 0, 0);
    chk("p_fv_early", bus.frame_valid, 0);
    step(1, 0, 0);
    chk("p_ok_data", bus.data_o, 16'h0003);
    chk("p_ok_fv", bus.frame_valid, 1);
    chk("p_ok_perr", bus.parity_err, 0);
    // slots 1,0..0 with wrong parity 0
    step(1, 1, 1);
    for (int k = 1; k < 8; k++) step(1, 0, 0);
    step(1, 0, 0);
    chk("p_bad_perr", bus.parity_err, 1);
    chk("p_bad_fv", bus.frame_valid, 0);
    chk("p_bad_data", bus.data_o, 16'h0003);
    chk("p_bad_lock", bus.locked, 1);
    // slots 3,0..0 with wrong parity 1
    step(1, 3, 1);
    chk("p_perr_clr", bus.parity_err, 0);
    for (int k = 1; k < 8; k++) step(1, 0, 0);
    step(1, 1, 0);
    chk("p_bad2_perr", bus.parity_err, 1);
    chk("p_bad2_data", bus.data_o, 16'h0003);
    // slots 1,0..0 with correct parity 1
    step(1, 1, 1);
    for (int k = 1; k < 8; k++) step(1, 0, 0);
    step(1, 1, 0);
    chk("p_ok2_data", bus.data_o, 16'h0001);
    chk("p_ok2_fv", bus.frame_valid, 1);
    chk("p_ok2_perr", bus.parity_err, 0);
    // sync on the parity beat is an early sync
    step(1, 2, 1);
    for (int k = 1; k < 8; k++) step(1, 0, 0);
    step(1, 1, 1);
    chk("p_early_serr", bus.sync_err, 1);
    chk("p_early_data", bus.data_o, 16'h0001);
`else
    // 0xAA back to back
    for (int k = 0; k < 7; k++) step(1, W'(k % 2), k == 0);
    chk("aa_fv_pre", bus.frame_valid, 0);
    chk("aa_lock", bus.locked, 1);
    step(1, 1, 0);
    chk("aa_data", bus.data_o, 8'hAA);
    chk("aa_fv", bus.frame_valid, 1);
    chk("aa_perr", bus.parity_err, 0);
    step(0, 0, 0);
    chk("aa_fv_pulse", bus.frame_valid, 0);

    // 0x55 with a 3-cycle gap; frame_sync ignored while idle
    for (int k = 0; k < 4; k++) step(1, W'((k + 1) % 2), k == 0);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    chk("gap_fv", bus.frame_valid, 0);
    chk("gap_serr", bus.sync_err, 0);
    for (int k = 4; k < 7; k++) step(1, W'((k + 1) % 2), 0);
    chk("gap_data_hold", bus.data_o, 8'hAA);
    step(1, 0, 0);
    chk("gap_data", bus.data_o, 8'h55);
    chk("gap_fv2", bus.frame_valid, 1);

    // early sync at cnt=4, then all-ones frame
    for (int k = 0; k < 4; k++) step(1, 0, k == 0);
    step(1, 1, 1);
    chk("early_serr", bus.sync_err, 1);
    chk("early_hold", bus.data_o, 8'h55);
    chk("early_lock", bus.locked, 1);
    for (int k = 1; k < 8; k++) step(1, 1, 0);
    chk("ff_data", bus.data_o, 8'hFF);
    chk("ff_fv", bus.frame_valid, 1);
    chk("ff_serr", bus.sync_err, 0);

    // missed sync
    step(1, 0, 0);
    chk("miss_serr", bus.sync_err, 1);
    chk("miss_lock", bus.locked, 0);
    chk("miss_data", bus.data_o, 8'hFF);
    for (int k = 0; k < 9; k++) step(1, 0, 0);
    chk("hunt_lock", bus.locked, 0);
    chk("hunt_data", bus.data_o, 8'hFF);
    chk("hunt_fv", bus.frame_valid, 0);
    chk("hunt_serr", bus.sync_err, 0);

    // reset mid-frame at cnt=5
    for (int k = 0; k < 5; k++) step(1, 1, k == 0);
    chk("pre_rst_lock", bus.locked, 1);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    chk("mrst_data", bus.data_o, 0);
    chk("mrst_lock", bus.locked, 0);
    chk("mrst_fv", bus.frame_valid, 0);
    for (int k = 0; k < 8; k++) step(1, W'(k < 4), k == 0);
    chk("f0f_data", bus.data_o, 8'h0F);
    chk("f0f_fv", bus.frame_valid, 1);

    // consecutive frames give consecutive-frame pulses
    for (int k = 0; k < 8; k++) step(1, W'(k == 7), k == 0);
    chk("b2b_data", bus.data_o, 8'h80);
    chk("b2b_fv", bus.frame_valid, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
